// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: a Moore FSM that sequences each instruction over
// 3-5 cycles through a shared ALU and a shared instruction/data memory port.
module multicycle_control_unit #(
  parameter int unsigned EXT_BRANCH = 1,
  parameter int unsigned EXT_ALU    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       ZERO,
  input  logic       LT,
  input  logic       LTU,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StLui,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } alu_op_e;

  state_e  r_state;
  state_e  w_next_state;
  alu_op_e w_alu_op;
  logic    w_taken;
  logic    w_ext_alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-state control; every enable is forced low while rst is high.
  always_comb begin
    w_next_state = r_state;
    w_alu_op     = AluOpAdd;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    instr_done   = 1'b0;
    illegal      = 1'b0;

    unique case (r_state)
      StFetch: begin
        MemReq    = 1'b1;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          w_next_state = StDecode;
        end
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (OP)
          OpLoad, OpStore: w_next_state = StMemAdr;
          OpReg:           w_next_state = StExecR;
          OpImm:           w_next_state = StExecI;
          OpBranch:        w_next_state = StBranch;
          OpJal:           w_next_state = StJal;
          OpLui:           w_next_state = StLui;
          default:         w_next_state = StTrap;
        endcase
      end
      StMemAdr: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        w_next_state = OP[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        MemReq = 1'b1;
        if (mem_ready) begin
          w_next_state = StMemWb;
        end
      end
      StMemWb: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        instr_done   = 1'b1;
        w_next_state = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done   = 1'b1;
          w_next_state = StFetch;
        end
      end
      StExecR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b00;
        w_alu_op     = AluOpFunct;
        w_next_state = StAluWb;
      end
      StExecI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        w_alu_op     = AluOpFunct;
        w_next_state = StAluWb;
      end
      StAluWb: begin
        ResultSrc    = 2'b00;
        RegWrite     = 1'b1;
        instr_done   = 1'b1;
        w_next_state = StFetch;
      end
      StBranch: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        w_alu_op     = AluOpSub;
        PCWrite      = w_taken;
        instr_done   = 1'b1;
        w_next_state = StFetch;
      end
      StJal: begin
        // ALUOut still holds the target computed in DECODE; ALU forms the link value.
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b00;
        PCWrite      = 1'b1;
        w_next_state = StAluWb;
      end
      StLui: begin
        ALUSrcA      = 2'b11;
        ALUSrcB      = 2'b01;
        w_next_state = StAluWb;
      end
      StTrap: begin
        illegal      = 1'b1;
        instr_done   = 1'b1;
        w_next_state = StFetch;
      end
      default: begin
        w_next_state = StFetch;
      end
    endcase

    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_comb begin
    case (OP)
      OpLoad, OpImm: ImmSrc = 3'b000;
      OpStore:       ImmSrc = 3'b001;
      OpBranch:      ImmSrc = 3'b010;
      OpJal:         ImmSrc = 3'b011;
      OpLui:         ImmSrc = 3'b100;
      default:       ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    if (EXT_BRANCH != 0) begin
      case (funct3)
        3'b000:  w_taken = ZERO;
        3'b001:  w_taken = ~ZERO;
        3'b100:  w_taken = LT;
        3'b101:  w_taken = ~LT;
        3'b110:  w_taken = LTU;
        3'b111:  w_taken = ~LTU;
        default: w_taken = 1'b0;
      endcase
    end else begin
      w_taken = (funct3 == 3'b000) & ZERO;
    end
  end

  // funct3 codes that only exist in the extended ALU set.
  assign w_ext_alu_op = (funct3 == 3'b100) || (funct3 == 3'b011) ||
                        (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    ALUControl = 4'b0000;
    unique case (w_alu_op)
      AluOpAdd: ALUControl = 4'b0000;
      AluOpSub: ALUControl = 4'b0001;
      AluOpFunct: begin
        case (funct3)
          3'b000:  ALUControl = (OP[5] & funct7b5) ? 4'b0001 : 4'b0000;
          3'b111:  ALUControl = 4'b0010;
          3'b110:  ALUControl = 4'b0011;
          3'b100:  ALUControl = 4'b0100;
          3'b010:  ALUControl = 4'b0101;
          3'b011:  ALUControl = 4'b0110;
          3'b001:  ALUControl = 4'b0111;
          3'b101:  ALUControl = funct7b5 ? 4'b1001 : 4'b1000;
          default: ALUControl = 4'b0000;
        endcase
        if ((EXT_ALU == 0) && w_ext_alu_op) begin
          ALUControl = 4'b0000;
        end
      end
      default: ALUControl = 4'b0000;
    endcase
  end

endmodule
